psum_col_accum: RTL and testbench

Partial-sum column accumulator: the consumer side of the per-pixel multiplier array. Each cycle it takes one vector of NO_COL_KERNEL products (one pixel times one kernel column) with its kernel-column index and pixel column. It adds each product into a NO_COL_KERNEL x NO_COL_OUTPUT signed accumulation buffer. When a row is done, it streams the completed top output row out serially with a valid/ready handshake, then shifts the buffer up one row.

---
 rtl/psum_col_accum_if.sv | 42 ++++
 rtl/psum_col_accum.sv | 135 +++++++++++++
 tb/tb_psum_col_accum.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_col_accum_if.sv
// ============================================================================
// psum_col_accum_if
// Product-vector input and serial output-row stream of the psum accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface psum_col_accum_if #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int NO_COL_OUTPUT = 12,
    parameter int ACC_WIDTH     = 20,
    parameter int CW            = $clog2(NO_COL_OUTPUT)
);
    logic                                   i_psum_valid;
    logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0]   i_feature_map_col;
    logic [2:0]                             i_kercol_cnt;
    logic [CW-1:0]                          i_pix_col;
    logic                                   i_row_done;
    logic                                   o_busy;
    logic                                   o_out_valid;
    logic                                   i_out_ready;
    logic signed [ACC_WIDTH-1:0]            o_pix_out;
    logic [CW-1:0]                          o_out_col;
    logic                                   o_row_last;
    logic                                   o_err;

    modport master (
        output i_psum_valid, i_feature_map_col, i_kercol_cnt, i_pix_col,
        output i_row_done, i_out_ready,
        input  o_busy, o_out_valid, o_pix_out, o_out_col, o_row_last, o_err
    );

    modport slave (
        input  i_psum_valid, i_feature_map_col, i_kercol_cnt, i_pix_col,
        input  i_row_done, i_out_ready,
        output o_busy, o_out_valid, o_pix_out, o_out_col, o_row_last, o_err
    );
endinterface

`default_nettype wire

// File: rtl/psum_col_accum.sv
// ============================================================================
// psum_col_accum
// Saturating partial-sum column buffer; drains the top row serially, then shifts up.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module psum_col_accum #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int NO_COL_OUTPUT = 12,
    parameter int ACC_WIDTH     = 20,
    parameter int CW            = $clog2(NO_COL_OUTPUT)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    psum_col_accum_if.slave    bus
);
    localparam int PW = 2 * BIT_WIDTH;
    localparam int TW = ((CW > 3) ? CW : 3) + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc_buf [NO_COL_KERNEL][NO_COL_OUTPUT];
    logic [CW-1:0]               col;
    logic                        busy;
    logic                        out_valid;
    logic                        err;

    logic signed [PW-1:0]        prod [NO_COL_KERNEL];
    logic [TW-1:0]               tgt;
    logic                        in_range;
    logic                        hit;
    logic                        drop;
    logic                        last_beat;

    for (genvar r = 0; r < NO_COL_KERNEL; r++) begin : g_prod
        assign prod[r] = bus.i_feature_map_col[r*PW +: PW];
    end

    assign tgt       = TW'(bus.i_pix_col) + TW'(bus.i_kercol_cnt);
    assign in_range  = (TW'(bus.i_kercol_cnt) < TW'(NO_COL_KERNEL)) &&
                       (tgt < TW'(NO_COL_OUTPUT));
    assign hit       = bus.i_psum_valid && (state == ST_ACCUM) && in_range;
    // Anything valid that is not accumulated is a lost product.
    assign drop      = bus.i_psum_valid && !hit;
    assign last_beat = (col == CW'(NO_COL_OUTPUT - 1));

    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [PW-1:0]        p
    );
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-PW){p[PW-1]}}, p};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_ACCUM;
            col       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            for (int r = 0; r < NO_COL_KERNEL; r++)
                for (int c = 0; c < NO_COL_OUTPUT; c++)
                    acc_buf[r][c] <= '0;
        end else begin
            if (drop)
                err <= 1'b1;
            case (state)
                ST_ACCUM: begin
                    if (hit) begin
                        for (int r = 0; r < NO_COL_KERNEL; r++)
                            for (int c = 0; c < NO_COL_OUTPUT; c++)
                                if (tgt == TW'(c))
                                    acc_buf[r][c] <= sat_add(acc_buf[r][c], prod[r]);
                    end
                    if (bus.i_row_done) begin
                        state     <= ST_DRAIN;
                        col       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.i_out_ready) begin
                        if (last_beat) begin
                            state     <= ST_SHIFT;
                            out_valid <= 1'b0;
                            col       <= '0;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    for (int r = 0; r < NO_COL_KERNEL - 1; r++)
                        for (int c = 0; c < NO_COL_OUTPUT; c++)
                            acc_buf[r][c] <= acc_buf[r+1][c];
                    for (int c = 0; c < NO_COL_OUTPUT; c++)
                        acc_buf[NO_COL_KERNEL-1][c] <= '0;
                    state <= ST_ACCUM;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_ACCUM;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Row 0 is frozen during a drain, so a direct read stays stable under stalls.
    assign bus.o_pix_out   = acc_buf[0][col];
    assign bus.o_out_col   = col;
    assign bus.o_out_valid = out_valid;
    assign bus.o_busy      = busy;
    assign bus.o_row_last  = out_valid && last_beat;
    assign bus.o_err       = err;

endmodule

`default_nettype wire

// File: tb/tb_psum_col_accum.sv
// ============================================================================
// tb_psum_col_accum
// Directed, table-driven self-checking bench for psum_col_accum.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_psum_col_accum;
    localparam int BW = 8;
    localparam int K  = 5;
    localparam int N  = 12;
    localparam int AW = 20;
    localparam int CW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_col_accum_if #(.BIT_WIDTH(BW), .NO_COL_KERNEL(K), .NO_COL_OUTPUT(N),
                        .ACC_WIDTH(AW), .CW(CW)) bus ();

    psum_col_accum #(.BIT_WIDTH(BW), .NO_COL_KERNEL(K), .NO_COL_OUTPUT(N),
                     .ACC_WIDTH(AW), .CW(CW)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int k;
        int p;
        int v;
        int reps;
        int col;
        int val;
        int err;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2*BW*K-1:0] pack5(input int a, input int b, input int c,
                                                input int d, input int e);
        logic [2*BW*K-1:0] f;
        f[15:0]  = 16'(a);
        f[31:16] = 16'(b);
        f[47:32] = 16'(c);
        f[63:48] = 16'(d);
        f[79:64] = 16'(e);
        return f;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int k, input int p, input logic [2*BW*K-1:0] fm);
        bus.i_psum_valid      = 1'b1;
        bus.i_kercol_cnt      = 3'(k);
        bus.i_pix_col         = CW'(p);
        bus.i_feature_map_col = fm;
        @(negedge clk);
        bus.i_psum_valid      = 1'b0;
    endtask

    task automatic drain(input bit toggle, input bit inject, input int exp [N],
                         output int busy_cnt);
        int nb = 0;
        int cyc = 0;
        int lasts = 0;
        bit stalled = 0;
        bit injected = 0;
        longint hp = 0;
        longint hc = 0;
        busy_cnt = 0;
        bus.i_row_done = 1'b1;
        @(negedge clk);
        bus.i_row_done = 1'b0;
        chk("drain_start_valid", bus.o_out_valid, 1);
        while (bus.o_busy && cyc < 400) begin
            busy_cnt++;
            if (nb < N) begin
                chk("valid_held", bus.o_out_valid, 1);
                if (stalled) begin
                    chk("stall_pix", bus.o_pix_out, hp);
                    chk("stall_col", bus.o_out_col, hc);
                end
                bus.i_out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
                if (inject && nb == 3 && !injected) begin
                    bus.i_psum_valid      = 1'b1;
                    bus.i_kercol_cnt      = 3'd0;
                    bus.i_pix_col         = CW'(2);
                    bus.i_feature_map_col = pack5(100, 100, 100, 100, 100);
                    injected = 1;
                end
                if (bus.i_out_ready) begin
                    chk("beat_col", bus.o_out_col, nb);
                    chk("beat_pix", bus.o_pix_out, exp[nb]);
                    chk("beat_last", bus.o_row_last, (nb == N-1) ? 1 : 0);
                    lasts += int'(bus.o_row_last);
                    nb++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hp = bus.o_pix_out;
                    hc = bus.o_out_col;
                end
            end else begin
                bus.i_out_ready = 1'b0;
                chk("shift_valid_low", bus.o_out_valid, 0);
            end
            @(negedge clk);
            bus.i_psum_valid = 1'b0;
            cyc++;
        end
        bus.i_out_ready = 1'b0;
        chk("drain_beats", nb, N);
        chk("drain_row_last_count", lasts, 1);
        chk("drain_busy_released", bus.o_busy, 0);
    endtask

    vec_t tbl [10];
    int   exp_row [N];
    int   bc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{k:2, p:3,  v:1,      reps:1,  col:5,  val:1,       err:0};
        tbl[1] = '{k:0, p:0,  v:100,    reps:2,  col:0,  val:200,     err:0};
        tbl[2] = '{k:4, p:7,  v:-50,    reps:3,  col:11, val:-150,    err:0};
        tbl[3] = '{k:0, p:11, v:7,      reps:1,  col:11, val:7,       err:0};
        tbl[4] = '{k:5, p:0,  v:9,      reps:1,  col:0,  val:0,       err:1};
        tbl[5] = '{k:3, p:10, v:9,      reps:1,  col:0,  val:0,       err:1};
        tbl[6] = '{k:1, p:11, v:9,      reps:1,  col:0,  val:0,       err:1};
        tbl[7] = '{k:0, p:4,  v:32767,  reps:17, col:4,  val:524287,  err:0};
        tbl[8] = '{k:0, p:4,  v:-32768, reps:17, col:4,  val:-524288, err:0};
        tbl[9] = '{k:4, p:0,  v:32767,  reps:16, col:4,  val:524272,  err:0};

        bus.i_psum_valid      = 1'b0;
        bus.i_feature_map_col = '0;
        bus.i_kercol_cnt      = '0;
        bus.i_pix_col         = '0;
        bus.i_row_done        = 1'b0;
        bus.i_out_ready       = 1'b0;

        do_reset();
        chk("rst_busy",     bus.o_busy, 0);
        chk("rst_valid",    bus.o_out_valid, 0);
        chk("rst_row_last", bus.o_row_last, 0);
        chk("rst_err",      bus.o_err, 0);
        chk("rst_pix",      bus.o_pix_out, 0);
        chk("rst_col",      bus.o_out_col, 0);

        // Empty drain straight after reset: zeros and a 13-cycle busy window.
        for (int i = 0; i < N; i++) exp_row[i] = 0;
        drain(0, 0, exp_row, bc);
        chk("busy_cycles", bc, N + 1);

        // One vector walks up through the rows on successive drains.
        send(2, 3, pack5(1, 2, 3, 4, 5));
        for (int d = 0; d < 6; d++) begin
            for (int i = 0; i < N; i++) exp_row[i] = 0;
            if (d < 5) exp_row[5] = d + 1;
            drain(0, 0, exp_row, bc);
        end

        // Overlapping kernel columns landing on the same output column.
        do_reset();
        send(1, 0, pack5(10, 0, 0, 0, 0));
        send(0, 1, pack5(-3, 0, 0, 0, 0));
        for (int i = 0; i < N; i++) exp_row[i] = 0;
        exp_row[1] = 7;
        drain(0, 0, exp_row, bc);

        // Backpressure: ready toggles every other cycle.
        do_reset();
        send(0, 0, pack5(11, 0, 0, 0, 0));
        send(1, 5, pack5(-22, 0, 0, 0, 0));
        send(4, 7, pack5(33, 0, 0, 0, 0));
        for (int i = 0; i < N; i++) exp_row[i] = 0;
        exp_row[0]  = 11;
        exp_row[6]  = -22;
        exp_row[11] = 33;
        drain(1, 0, exp_row, bc);

        for (int t = 0; t < 10; t++) begin
            do_reset();
            for (int n = 0; n < tbl[t].reps; n++)
                send(tbl[t].k, tbl[t].p, pack5(tbl[t].v, 0, 0, 0, 0));
            chk("tbl_err", bus.o_err, tbl[t].err);
            for (int i = 0; i < N; i++) exp_row[i] = 0;
            exp_row[tbl[t].col] = tbl[t].val;
            drain(0, 0, exp_row, bc);
        end

        // Psum arriving mid-drain is dropped and flags a sticky error.
        do_reset();
        send(0, 2, pack5(5, 0, 0, 0, 0));
        chk("pre_inject_err", bus.o_err, 0);
        for (int i = 0; i < N; i++) exp_row[i] = 0;
        exp_row[2] = 5;
        drain(0, 1, exp_row, bc);
        chk("inject_err", bus.o_err, 1);
        exp_row[2] = 0;
        drain(0, 0, exp_row, bc);
        repeat (5) @(negedge clk);
        chk("err_sticky", bus.o_err, 1);
        do_reset();
        chk("err_cleared", bus.o_err, 0);

        // Asynchronous reset in the middle of a drain.
        send(0, 0, pack5(9, 0, 0, 0, 0));
        bus.i_row_done = 1'b1;
        @(negedge clk);
        bus.i_row_done  = 1'b0;
        bus.i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",  bus.o_busy, 0);
        chk("midrst_valid", bus.o_out_valid, 0);
        chk("midrst_last",  bus.o_row_last, 0);
        chk("midrst_pix",   bus.o_pix_out, 0);
        chk("midrst_col",   bus.o_out_col, 0);
        bus.i_out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) exp_row[i] = 0;
        drain(0, 0, exp_row, bc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
